regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of writeback requesters (0=LSU, 1=MDU, 2=ALU).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_i  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port req_valid_i  input  NREQ  per-requester writeback request.
REQ-005 SHALL have port req_addr_i  input  NREQ x regaddr_t  destination register per requester.
REQ-006 SHALL have port req_data_i  input  NREQ x size_t  write data per requester.
REQ-007 SHALL have port req_ready_o  output  NREQ  grant; transfer when valid and ready both high at a rising edge.
REQ-008 SHALL have port rsv_valid_i  input  1  decode reserves a destination register.
REQ-009 SHALL have port rsv_addr_i  input  regaddr_t  register being reserved.
REQ-010 SHALL have port wr_en_o  output  1  regfile write enable.
REQ-011 SHALL have port wr_addr_o  output  regaddr_t  regfile write address.
REQ-012 SHALL have port wr_data_o  output  size_t  regfile write data.
REQ-013 SHALL have port busy_o  output  32  per-register pending-write scoreboard.

Function
REQ-014 SHALL assert at most one req_ready_o bit per cycle, and only for a requester with req_valid_i high.
REQ-015 SHALL derive req_ready_o combinationally from req_valid_i and arbitration state; requesters SHALL NOT gate valid on ready.
REQ-016 SHALL assert no grant when no request is valid; arbitration state holds.
REQ-017 SHALL register the granted address/data: transfer in cycle N drives wr_en_o=1 with that address/data in cycle N+1, exactly one cycle.
REQ-018 SHALL drive wr_en_o=0 and hold wr_addr_o/wr_data_o at their last values in cycles with no transfer.
REQ-019 SHALL accept a request to register 0 normally (ready asserted) but force wr_en_o=0 for it.
REQ-020 SHALL set busy_o[rsv_addr_i] at the edge where rsv_valid_i=1, except register 0, which is never busy.
REQ-021 SHALL clear busy_o[wr_addr_o] at the edge ending a cycle with wr_en_o=1.
REQ-022 SHALL leave the bit set when a set and a clear of the same register fall on the same edge; reservation wins.
REQ-023 SHALL accept a writeback to a non-busy register without error; busy_o stays 0.
REQ-024 SHALL support back-to-back transfers every cycle with no bubble.

Reset
REQ-025 SHALL, while reset_i=0, force req_ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, and the round-robin pointer to 0, asynchronously.
REQ-026 SHALL drop any transfer captured but not yet driven on wr_en_o when reset asserts mid-operation.
REQ-027 SHALL grant normally in the first cycle after reset_i deasserts.

Configuration
REQ-028 SHALL, with WB_ARB_ROUND_ROBIN_EN defined, grant round-robin: search starts at the index after the last granted one, and the pointer advances only on a transfer.
REQ-029 SHALL, without WB_ARB_ROUND_ROBIN_EN, grant by fixed priority, lowest index wins, with no pointer state.

Structure
REQ-030 SHALL take regaddr_t and size_t from package codes; requester index constants (REQ_LSU=0, REQ_MDU=1, REQ_ALU=2) SHALL be added to codes.
REQ-031 SHALL place grant selection in sub-module wb_rr_picker: valid vector and pointer in, one-hot grant out.
REQ-032 SHALL keep the scoreboard and output register in the top module.

Verification
REQ-033 SHALL cover: ALU valid, addr 5, data 0xDEADBEEF, alone -> ready[2]=1 that cycle; next cycle wr_en_o=1, wr_addr_o=5, wr_data_o=0xDEADBEEF.
REQ-034 SHALL cover: all three valid held 6 cycles -> round-robin grants 0,1,2,0,1,2; fixed-priority grants 0 every cycle, 1 and 2 stall.
REQ-035 SHALL cover: LSU writes addr 0, data 0x1234 -> ready[0]=1, next cycle wr_en_o=0; reservation of reg 0 -> busy_o[0]=0.
REQ-036 SHALL cover: reserve reg 9, then writeback reg 9 -> busy_o[9]=1 until the edge after wr_en_o=1, then 0; new reserve of 9 on the clearing edge -> busy_o[9] stays 1.
REQ-037 SHALL cover: reset_i low mid-burst, with wr_en_o due next cycle -> all outputs 0 immediately, no write after release, busy_o=0.
REQ-038 SHALL cover: continuous ALU valid for 4 cycles, new addr/data each -> four consecutive wr_en_o=1 cycles in order, no gaps.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// ============================================================================
// Package     : codes
// Description : Shared types for the register-file writeback path: register
//               address and data word types, plus writeback requester indices.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package codes;

  // Architectural register index (32 registers)
  typedef logic [4:0]  regaddr_t;

  // Register data word
  typedef logic [31:0] size_t;

  // Writeback requester indices
  localparam int REQ_LSU = 0;
  localparam int REQ_MDU = 1;
  localparam int REQ_ALU = 2;

endpackage : codes

`default_nettype wire

// File: rtl/regfile_wb_arbiter_picker.sv
// ============================================================================
// Module      : wb_rr_picker
// Description : Combinational grant selector. Scans the valid vector starting
//               at ptr_i, wrapping around, and returns a one-hot grant for the
//               first valid requester found. A pointer held at zero yields
//               plain lowest-index-wins priority.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_rr_picker #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o
);

  logic found;

  // Rotating first-one search starting at the pointer position
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && valid_i[j] && (((int'(ptr_i) + k) % NREQ) == j)) begin
          grant_o[j] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule : wb_rr_picker

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Arbitrates NREQ writeback requesters onto a single register
//               file write port (one registered write per transfer) and keeps
//               a per-register pending-write scoreboard.
//               Build option: define WB_ARB_ROUND_ROBIN_EN for round-robin
//               arbitration; otherwise fixed priority, lowest index wins.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
  import codes::*;
#(
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic     [NREQ-1:0]  req_valid_i,
  input  regaddr_t [NREQ-1:0]  req_addr_i,
  input  size_t    [NREQ-1:0]  req_data_i,
  output logic     [NREQ-1:0]  req_ready_o,
  input  logic                 rsv_valid_i,
  input  regaddr_t             rsv_addr_i,
  output logic                 wr_en_o,
  output regaddr_t             wr_addr_o,
  output size_t                wr_data_o,
  output logic     [31:0]      busy_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   ptr;
  logic            xfer;
  regaddr_t        sel_addr;
  size_t           sel_data;

  logic            wr_en_q;
  regaddr_t        wr_addr_q;
  size_t           wr_data_q;
  logic [31:0]     busy_q;
  logic [31:0]     busy_d;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   ptr_d;
  logic [PW-1:0]   sel_idx;

  assign ptr = ptr_q;

  // Granted index; the next search starts just past it
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_idx = PW'(i);
    end
    ptr_d = ptr_q;
    if (xfer) ptr_d = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
  end

  // Round-robin pointer moves only when a transfer happens
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`else
  // Fixed priority: search always starts at requester 0
  assign ptr = '0;
`endif

  wb_rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .valid_i (req_valid_i),
    .ptr_i   (ptr),
    .grant_o (grant)
  );

  // Ready is suppressed while reset is asserted
  assign req_ready_o = grant & {NREQ{reset_i}};
  assign xfer        = |req_ready_o;

  // One-hot mux of the granted requester's address and data
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = sel_addr | req_addr_i[i];
        sel_data = sel_data | req_data_i[i];
      end
    end
  end

  // Write port register: one-cycle write per transfer, register 0 never written
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= xfer && (sel_addr != '0);
      if (xfer) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
    end
  end

  // Scoreboard next state: clear on completed write, then reservation wins
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q)     busy_d[wr_addr_q]  = 1'b0;
    if (rsv_valid_i) busy_d[rsv_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = busy_q;

endmodule : regfile_wb_arbiter

`default_nettype wire
